csi2_pixel_to_video: RTL and testbench
======================================

Name: csi2_pixel_to_video

Overview:
Second stage of the CSI-2 receive path. It sits after csi2_rx_to_pixel, which parses lane bytes into packet headers and payload words. This block turns that packet-level stream into a registered video-style stream: frame sync, active-video qualifier, pixel-byte word and data identifier. Its output feeds the downstream video-in / AXI-Stream bridge.

Parameters:
LANES_NUM, 4, number of D-PHY lanes; the payload word holds LANES_NUM bytes (legal 1, 2, 4).
DATA_BITS, 8, bits per lane byte in the payload word.

Ports:
clk_byte  in  1  byte clock; all logic is on its rising edge.
rst_n  in  1  reset, asynchronous and active-low.
pix_valid  in  1  one-cycle pulse: a packet header (short or long) was decoded.
pix_di  in  8  data identifier {VC[7:6], DT[5:0]}; sampled when pix_valid=1.
pix_data  in  LANES_NUM*DATA_BITS  payload word; byte 0 (first received) in bits [DATA_BITS-1:0].
pix_data_enable  in  1  pix_data holds a valid payload word of the current long packet.
vid_ce  out  1  output beat qualifier.
vid_di  out  8  DI of the packet currently driving the outputs.
vid_locked  out  1  a complete frame (FS..FE) has been seen and framing is consistent.
vid_vsync  out  1  frame-start pulse.
vid_active_video  out  1  vid_data carries image payload.
vid_data  out  LANES_NUM*DATA_BITS  registered payload word.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; internal in_frame=0; current-DI register=0.
- All outputs are registered. Latency is 1 clk_byte cycle from input to output.
- Header decode (pix_valid=1), with DT=pix_di[5:0]:
  - DT 0x00 (Frame Start):
    - next cycle vid_vsync=1 and vid_ce=1, each for exactly 1 cycle; vid_di=pix_di.
    - If in_frame was already 1 (FE missing), vid_locked is cleared.
    - in_frame is then set to 1.
  - DT 0x01 (Frame End):
    - If in_frame=1, vid_locked is set to 1 (held until reset or an error).
    - If in_frame=0, vid_locked is cleared.
    - in_frame is cleared in both cases.
    - No output beat is generated.
  - DT 0x02..0x0F (other short packets): ignored; no state change.
  - DT 0x10..0x17 (null / blanking / embedded / generic long): the current-DI register is loaded and line_is_image is cleared.
  - DT 0x18..0x3F (image long packets, e.g. 0x2B RAW10): the current-DI register is loaded and line_is_image is set.
- Payload (pix_data_enable=1):
  - If in_frame=1 and line_is_image=1: next cycle vid_active_video=1, vid_ce=1, vid_data=pix_data, vid_di=current-DI register.
  - Otherwise the word is dropped: vid_active_video=0, vid_ce=0, vid_data holds its last value.
- When neither event occurs: vid_ce=0, vid_active_video=0, vid_vsync=0; vid_data and vid_di hold.
- Simultaneous pix_valid and pix_data_enable: the header is processed first (new DI and flags apply), then the word is qualified with the updated state.
- The block does no unpacking. RAW10 LSB bytes (e.g. 0xE4) pass through in vid_data unchanged; pixel unpacking is downstream.
- Gaps between payload words (pix_data_enable low mid-packet) simply deassert vid_active_video for those cycles.
- VC bits are not filtered; all virtual channels are accepted.
- Mid-operation reset: outputs clear immediately. After release, the block needs a full FS..FE frame before vid_locked=1 again. Payload arriving before the first FS is dropped.

Test Plan:
- Reset: hold rst_n=0 while driving pix_data_enable=1 -> all outputs 0. Release rst_n -> vid_locked=0; payload before an FS is dropped (vid_active_video stays 0).
- FS then FE: pix_valid with pix_di=0x00 -> vid_vsync=1 and vid_ce=1 for exactly 1 cycle, 1 cycle later. Then pix_valid with pix_di=0x01 -> vid_locked rises 1 cycle later and stays 1.
- RAW10 line, LANES_NUM=4: header DI 0x2B, then words 0x03020100, 0x060504E4, 0x0908E407, 0x0CE40B0A, 0xE40F0E0D, 0x13121110, 0x5A5A5AE4 -> 7 consecutive beats with vid_active_video=1, vid_ce=1, vid_di=0x2B, vid_data equal to the inputs, each 1 cycle late.
- LANES_NUM=2 and LANES_NUM=1 builds: same frame of 10 RAW10 lines, 16-bit words (0x0100, 0x0302, ...) and 8-bit words -> vid_data matches the input stream byte for byte. Each frame yields 1 vsync pulse and 10 active bursts.
- Embedded-data packet (DI 0x12) inside a frame -> payload dropped, vid_active_video=0. Next 0x2B line -> output resumes.
- Error case: FS, then a second FS without an FE -> vid_locked drops to 0. After the next FE, vid_locked returns to 1.

Source files
------------

// File: rtl/csi2_pixel_to_video.sv
// CSI-2 receive, second stage: turns decoded packet headers and payload words into a
// registered video stream (frame sync, active-video qualifier, data word, data identifier).
module csi2_pixel_to_video #(
    parameter int LANES_NUM = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                           clk_byte,
    input  logic                           rst_n,
    input  logic                           pix_valid,
    input  logic [7:0]                     pix_di,
    input  logic [LANES_NUM*DATA_BITS-1:0] pix_data,
    input  logic                           pix_data_enable,
    output logic                           vid_ce,
    output logic [7:0]                     vid_di,
    output logic                           vid_locked,
    output logic                           vid_vsync,
    output logic                           vid_active_video,
    output logic [LANES_NUM*DATA_BITS-1:0] vid_data
);

    localparam int W = LANES_NUM * DATA_BITS;

    logic         in_frame_q, in_frame_d;
    logic         line_img_q, line_img_d;
    logic [7:0]   cur_di_q, cur_di_d;
    logic         ce_q, ce_d;
    logic [7:0]   di_q, di_d;
    logic         locked_q, locked_d;
    logic         vsync_q, vsync_d;
    logic         active_q, active_d;
    logic [W-1:0] data_q, data_d;
    logic [5:0]   dt;

    assign dt = pix_di[5:0];

    always_comb begin
        in_frame_d = in_frame_q;
        line_img_d = line_img_q;
        cur_di_d   = cur_di_q;
        ce_d       = 1'b0;
        di_d       = di_q;
        locked_d   = locked_q;
        vsync_d    = 1'b0;
        active_d   = 1'b0;
        data_d     = data_q;

        if (pix_valid) begin
            if (dt == 6'h00) begin
                // A second FS without an intervening FE means framing was lost.
                vsync_d    = 1'b1;
                ce_d       = 1'b1;
                di_d       = pix_di;
                in_frame_d = 1'b1;
                if (in_frame_q) begin
                    locked_d = 1'b0;
                end
            end else if (dt == 6'h01) begin
                locked_d   = in_frame_q;
                in_frame_d = 1'b0;
            end else if (dt >= 6'h10) begin
                cur_di_d   = pix_di;
                line_img_d = (dt >= 6'h18);
            end
        end

        // Payload is qualified against the state after any same-cycle header.
        if (pix_data_enable && in_frame_d && line_img_d) begin
            active_d = 1'b1;
            ce_d     = 1'b1;
            data_d   = pix_data;
            di_d     = cur_di_d;
        end
    end

    always_ff @(posedge clk_byte or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_q <= 1'b0;
            line_img_q <= 1'b0;
            cur_di_q   <= 8'h00;
            ce_q       <= 1'b0;
            di_q       <= 8'h00;
            locked_q   <= 1'b0;
            vsync_q    <= 1'b0;
            active_q   <= 1'b0;
            data_q     <= '0;
        end else begin
            in_frame_q <= in_frame_d;
            line_img_q <= line_img_d;
            cur_di_q   <= cur_di_d;
            ce_q       <= ce_d;
            di_q       <= di_d;
            locked_q   <= locked_d;
            vsync_q    <= vsync_d;
            active_q   <= active_d;
            data_q     <= data_d;
        end
    end

    assign vid_ce           = ce_q;
    assign vid_di           = di_q;
    assign vid_locked       = locked_q;
    assign vid_vsync        = vsync_q;
    assign vid_active_video = active_q;
    assign vid_data         = data_q;

endmodule

// File: tb/tb_csi2_pixel_to_video.sv
// Bench for csi2_pixel_to_video (LANES_NUM=4): directed packets, expected beats queued
// by the stimulus and checked by an independent output monitor.
module tb_csi2_pixel_to_video;

    logic        clk_byte = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [7:0]  pix_di;
    logic [31:0] pix_data;
    logic        pix_data_enable;
    logic        vid_ce;
    logic [7:0]  vid_di;
    logic        vid_locked;
    logic        vid_vsync;
    logic        vid_active_video;
    logic [31:0] vid_data;

    csi2_pixel_to_video #(.LANES_NUM(4), .DATA_BITS(8)) dut (
        .clk_byte        (clk_byte),
        .rst_n           (rst_n),
        .pix_valid       (pix_valid),
        .pix_di          (pix_di),
        .pix_data        (pix_data),
        .pix_data_enable (pix_data_enable),
        .vid_ce          (vid_ce),
        .vid_di          (vid_di),
        .vid_locked      (vid_locked),
        .vid_vsync       (vid_vsync),
        .vid_active_video(vid_active_video),
        .vid_data        (vid_data)
    );

    always #5 clk_byte = ~clk_byte;

    typedef struct packed {
        logic        vs;
        logic        act;
        logic [7:0]  di;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_data = 32'h0;

    logic [31:0] raw10_words [7] = '{32'h03020100, 32'h060504E4, 32'h0908E407, 32'h0CE40B0A,
                                     32'hE40F0E0D, 32'h13121110, 32'h5A5A5AE4};

    // Output monitor: every vid_ce beat must match the oldest queued expectation.
    always @(negedge clk_byte) begin
        beat_t e;
        if (vid_ce) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat got vs=%0b act=%0b di=%h data=%h, required no beat",
                         vid_vsync, vid_active_video, vid_di, vid_data);
            end else begin
                e = exp_q.pop_front();
                if ({vid_vsync, vid_active_video, vid_di, vid_data} !== e) begin
                    fails++;
                    $display("FAIL beat got vs=%0b act=%0b di=%h data=%h, required vs=%0b act=%0b di=%h data=%h",
                             vid_vsync, vid_active_video, vid_di, vid_data, e.vs, e.act, e.di, e.data);
                end
            end
        end else if (vid_vsync || vid_active_video) begin
            tests++;
            fails++;
            $display("FAIL stray_qualifier got vs=%0b act=%0b with ce=0, required 0 0",
                     vid_vsync, vid_active_video);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] di, input logic de, input logic [31:0] d);
        @(negedge clk_byte);
        pix_valid       = v;
        pix_di          = di;
        pix_data_enable = de;
        pix_data        = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 32'h0);
    endtask

    task automatic fs(input logic [7:0] di);
        exp_q.push_back('{vs: 1'b1, act: 1'b0, di: di, data: exp_data});
        drive(1'b1, di, 1'b0, 32'h0);
    endtask

    task automatic hdr(input logic [7:0] di);
        drive(1'b1, di, 1'b0, 32'h0);
    endtask

    task automatic word(input logic [31:0] d, input logic expect_on, input logic [7:0] di);
        if (expect_on) begin
            exp_q.push_back('{vs: 1'b0, act: 1'b1, di: di, data: d});
            exp_data = d;
        end
        drive(1'b0, 8'h00, 1'b1, d);
    endtask

    initial begin
        rst_n = 1'b0;
        pix_valid = 1'b0; pix_di = 8'h00;
        pix_data_enable = 1'b1; pix_data = 32'hDEADBEEF;
        repeat (3) @(negedge clk_byte);
        chk("reset_ce", {31'b0, vid_ce}, 32'h0);
        chk("reset_vsync_active_locked", {29'b0, vid_vsync, vid_active_video, vid_locked}, 32'h0);
        chk("reset_di", {24'b0, vid_di}, 32'h0);
        chk("reset_data", vid_data, 32'h0);

        // Release; payload before any FS must be dropped.
        rst_n = 1'b1;
        word(32'h11223344, 1'b0, 8'h00);
        word(32'h55667788, 1'b0, 8'h00);
        idle(1);
        chk("pre_fs_locked", {31'b0, vid_locked}, 32'h0);
        chk("pre_fs_data_held", vid_data, 32'h0);

        // FS then FE locks.
        fs(8'h00);
        idle(2);
        chk("locked_before_fe", {31'b0, vid_locked}, 32'h0);
        hdr(8'h01);
        idle(1);
        chk("locked_after_fe", {31'b0, vid_locked}, 32'h1);

        // RAW10 line, seven back-to-back words.
        fs(8'h00);
        hdr(8'h2B);
        for (int i = 0; i < 7; i++) word(raw10_words[i], 1'b1, 8'h2B);
        idle(2);
        chk("data_held_after_line", vid_data, 32'h5A5A5AE4);

        // Embedded data dropped, then image resumes with a gap mid-line.
        hdr(8'h12);
        word(32'hAAAA0001, 1'b0, 8'h00);
        word(32'hAAAA0002, 1'b0, 8'h00);
        idle(1);
        chk("embedded_di_held", {24'b0, vid_di}, 32'h2B);
        hdr(8'h2B);
        word(32'h00000101, 1'b1, 8'h2B);
        idle(2);
        word(32'h00000202, 1'b1, 8'h2B);
        // Other short packet inside a line changes nothing.
        hdr(8'h05);
        word(32'h00000303, 1'b1, 8'h2B);
        // Header and word in the same cycle: word is qualified by the new header.
        hdr(8'h12);
        exp_q.push_back('{vs: 1'b0, act: 1'b1, di: 8'h6B, data: 32'hCAFEF00D});
        exp_data = 32'hCAFEF00D;
        drive(1'b1, 8'h6B, 1'b1, 32'hCAFEF00D);
        drive(1'b1, 8'h12, 1'b1, 32'hBAD0BAD0);
        idle(1);
        hdr(8'h01);
        idle(1);
        chk("locked_after_second_frame", {31'b0, vid_locked}, 32'h1);

        // Outside a frame, even an image line is dropped.
        hdr(8'h2B);
        word(32'h0BADF00D, 1'b0, 8'h00);
        idle(1);

        // Missing FE: second FS clears lock, next FE restores it.
        fs(8'h40);
        idle(1);
        fs(8'h00);
        idle(1);
        chk("locked_after_double_fs", {31'b0, vid_locked}, 32'h0);
        hdr(8'h01);
        idle(1);
        chk("locked_after_recovery_fe", {31'b0, vid_locked}, 32'h1);

        // Mid-frame reset.
        fs(8'h00);
        hdr(8'h2B);
        word(32'h12345678, 1'b1, 8'h2B);
        idle(2);
        @(negedge clk_byte);
        rst_n = 1'b0;
        #1;
        chk("midreset_locked", {31'b0, vid_locked}, 32'h0);
        chk("midreset_data", vid_data, 32'h0);
        exp_data = 32'h0;
        idle(1);
        rst_n = 1'b1;
        hdr(8'h2B);
        word(32'h87654321, 1'b0, 8'h00);
        hdr(8'h01);
        idle(1);
        chk("fe_without_fs_after_reset", {31'b0, vid_locked}, 32'h0);
        fs(8'h00);
        hdr(8'h2B);
        word(32'h0F0E0D0C, 1'b1, 8'h2B);
        hdr(8'h01);
        idle(1);
        chk("relock_after_reset", {31'b0, vid_locked}, 32'h1);

        idle(3);
        chk("beats_outstanding", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
